power_accumulator: RTL and testbench

- Parametrised successor of the single-mode running accumulator. Accepts one unsigned sample per enabled cycle and accumulates x, x^2 or x^3 into a wide register, selectable per sample.
- Pipelined at 3 cycles. Adds synchronous clear, a sample counter, a result-valid strobe, and saturation with a sticky overflow flag.
- Sits after the sample source; its outputs feed statistics/readout logic.

---
 rtl/power_accumulator_if.sv | 37 +++
 rtl/power_accumulator.sv | 138 +++++++++++++
 tb/tb_power_accumulator.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/power_accumulator_if.sv
// power_accumulator_if
//   Sample/result bundle for power_accumulator.
//   master : sample source side, drives clr/en/mode/x and observes results.
//   slave  : accumulator side, consumes samples and drives y/valid/cnt/ovf.
//   Signals:
//     clr   synchronous clear of accumulator, counter, overflow and pipeline
//     en    sample strobe
//     mode  0: x, 1: x^2, 2: x^3, 3: treated as 0
//     x     unsigned sample (DATA_W)
//     y     accumulated sum (W)
//     valid one-cycle pulse per absorbed sample
//     cnt   saturating absorbed-sample count (CNT_W)
//     ovf   sticky saturation flag
interface power_accumulator_if #(
    parameter int DATA_W = 32,
    parameter int W      = 98,
    parameter int CNT_W  = 16
);
    logic              clr;
    logic              en;
    logic [1:0]        mode;
    logic [DATA_W-1:0] x;
    logic [W-1:0]      y;
    logic              valid;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;

    modport master (
        output clr, en, mode, x,
        input  y, valid, cnt, ovf
    );

    modport slave (
        input  clr, en, mode, x,
        output y, valid, cnt, ovf
    );
endinterface

// File: rtl/power_accumulator.sv
// power_accumulator
//   Pipelined running accumulator of x, x^2 or x^3 (selected per sample),
//   with saturation, sticky overflow, saturating sample counter and a
//   result-valid strobe. A sample captured at edge n lands in y at edge n+3.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-high reset (priority over everything)
//     bus  power_accumulator_if.slave: clr/en/mode/x in, y/valid/cnt/ovf out
//   All outputs are registered.
module power_accumulator #(
    parameter int DATA_W = 32,
    parameter int W      = 98,
    parameter int CNT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    power_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_LIN  = 2'd0,
        MODE_SQ   = 2'd1,
        MODE_CUBE = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    localparam int TERM_W = 3 * DATA_W;
    localparam int SQ_W   = 2 * DATA_W;
    // One bit beyond the wider of accumulator and term, so the raw sum never wraps.
    localparam int SUM_W  = ((W > TERM_W) ? W : TERM_W) + 1;

    // Stage 1: captured sample
    logic              s1_vld;
    logic [DATA_W-1:0] s1_x;
    mode_t             s1_mode;

    // Stage 2: sample and its square
    logic              s2_vld;
    logic [DATA_W-1:0] s2_x;
    logic [SQ_W-1:0]   s2_sq;
    mode_t             s2_mode;

    // Stage 3: selected term
    logic              s3_vld;
    logic [TERM_W-1:0] s3_term;

    // Accumulate stage / outputs
    logic [W-1:0]      y_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic              valid_q;

    // Combinational datapath between stages
    logic [SQ_W-1:0]   s1_x_ext;
    logic [SQ_W-1:0]   sq_c;
    logic [TERM_W-1:0] s2_x_ext;
    logic [TERM_W-1:0] s2_sq_ext;
    logic [TERM_W-1:0] cube_c;
    logic [TERM_W-1:0] term_c;
    logic [SUM_W-1:0]  sum_c;
    logic              sat_c;

    assign s1_x_ext  = {{DATA_W{1'b0}}, s1_x};
    assign sq_c      = s1_x_ext * s1_x_ext;

    assign s2_x_ext  = {{SQ_W{1'b0}}, s2_x};
    assign s2_sq_ext = {{DATA_W{1'b0}}, s2_sq};
    assign cube_c    = s2_sq_ext * s2_x_ext;

    always_comb begin
        term_c = s2_x_ext;
        case (s2_mode)
            MODE_SQ:   term_c = s2_sq_ext;
            MODE_CUBE: term_c = cube_c;
            default:   term_c = s2_x_ext;
        endcase
    end

    // Both operands zero-extended to SUM_W; any bit at or above W means the
    // true sum no longer fits the accumulator.
    assign sum_c = {{(SUM_W - W){1'b0}}, y_q} + {{(SUM_W - TERM_W){1'b0}}, s3_term};
    assign sat_c = |sum_c[SUM_W-1:W];

    // Data registers carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (bus.en) begin
            s1_x    <= bus.x;
            s1_mode <= mode_t'(bus.mode);
        end
        s2_x    <= s1_x;
        s2_sq   <= sq_c;
        s2_mode <= s1_mode;
        s3_term <= term_c;
    end

    // Control and accumulator. clr flushes S2/S3 and the result state, but
    // S1 still captures a sample presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s3_vld  <= 1'b0;
            y_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s1_vld <= bus.en;
            s2_vld <= s1_vld & ~bus.clr;
            s3_vld <= s2_vld & ~bus.clr;
            if (bus.clr) begin
                y_q     <= '0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= s3_vld;
                if (s3_vld) begin
                    if (sat_c) begin
                        y_q   <= '1;
                        ovf_q <= 1'b1;
                    end else begin
                        y_q <= sum_c[W-1:0];
                    end
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.y     = y_q;
    assign bus.cnt   = cnt_q;
    assign bus.ovf   = ovf_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_power_accumulator.sv
// tb_power_accumulator
//   Drives three power_accumulator instances with the same directed stimulus:
//     d0: DATA_W=32, W=98, CNT_W=16 (default geometry)
//     d1: DATA_W=4,  W=8,  CNT_W=16 (saturation)
//     d2: DATA_W=8,  W=32, CNT_W=3  (counter saturation)
//   A schedule-based model predicts every output each cycle; literal checks
//   pin key results.
module tb_power_accumulator;

    logic clk;
    logic rst;

    power_accumulator_if #(.DATA_W(32), .W(98), .CNT_W(16)) b0 ();
    power_accumulator_if #(.DATA_W(4),  .W(8),  .CNT_W(16)) b1 ();
    power_accumulator_if #(.DATA_W(8),  .W(32), .CNT_W(3))  b2 ();

    power_accumulator #(.DATA_W(32), .W(98), .CNT_W(16)) d0 (.clk(clk), .rst(rst), .bus(b0));
    power_accumulator #(.DATA_W(4),  .W(8),  .CNT_W(16)) d1 (.clk(clk), .rst(rst), .bus(b1));
    power_accumulator #(.DATA_W(8),  .W(32), .CNT_W(3))  d2 (.clk(clk), .rst(rst), .bus(b2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int vcnt0    = 0;
    int edge_no  = 0;

    // Model: y/cnt/ovf/valid after each edge, and samples scheduled by the
    // edge at which they must be absorbed (slot = due edge mod 4).
    logic [255:0] m_y   [3];
    int unsigned  m_cnt [3];
    bit           m_ovf [3];
    bit           m_vld [3];
    bit           pv    [3][4];
    logic [255:0] px    [3][4];
    logic [1:0]   pm    [3][4];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input int i, input bit r, input bit c, input bit e,
                              input logic [1:0] m, input logic [255:0] xv,
                              input int w, input int cw);
        int slot;
        logic [255:0] t, s, mx;
        if (r) begin
            for (int k = 0; k < 4; k++) pv[i][k] = 1'b0;
            m_y[i] = '0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_vld[i] = 1'b0;
            return;
        end
        slot = edge_no % 4;
        if (c) begin
            for (int k = 0; k < 4; k++) pv[i][k] = 1'b0;
            m_y[i] = '0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_vld[i] = 1'b0;
        end else if (pv[i][slot]) begin
            pv[i][slot] = 1'b0;
            case (pm[i][slot])
                2'd1:    t = px[i][slot] * px[i][slot];
                2'd2:    t = px[i][slot] * px[i][slot] * px[i][slot];
                default: t = px[i][slot];
            endcase
            mx = (256'(1) << w) - 256'(1);
            s  = m_y[i] + t;
            if (s > mx) begin
                m_y[i] = mx;
                m_ovf[i] = 1'b1;
            end else begin
                m_y[i] = s;
            end
            if (m_cnt[i] < (32'd1 << cw) - 1) m_cnt[i]++;
            m_vld[i] = 1'b1;
        end else begin
            m_vld[i] = 1'b0;
        end
        if (e) begin
            pv[i][(edge_no + 3) % 4] = 1'b1;
            px[i][(edge_no + 3) % 4] = xv;
            pm[i][(edge_no + 3) % 4] = m;
        end
    endtask

    // One clock edge; the model sees the same inputs the DUTs sampled.
    task automatic step();
        @(posedge clk);
        #1;
        edge_no++;
        model_edge(0, rst, b0.clr, b0.en, b0.mode, 256'(b0.x), 98, 16);
        model_edge(1, rst, b1.clr, b1.en, b1.mode, 256'(b1.x), 8, 16);
        model_edge(2, rst, b2.clr, b2.en, b2.mode, 256'(b2.x), 32, 3);
        chk_en = 1'b1;
    endtask

    task automatic drive(input bit r, input bit c, input bit e, input logic [1:0] m, input logic [31:0] xv);
        rst = r;
        b0.clr = c; b0.en = e; b0.mode = m; b0.x = xv;
        b1.clr = c; b1.en = e; b1.mode = m; b1.x = xv[3:0];
        b2.clr = c; b2.en = e; b2.mode = m; b2.x = xv[7:0];
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear();
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
        step();
        idle(1);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("d0.y",     256'(b0.y),     m_y[0]);
            chk("d0.cnt",   256'(b0.cnt),   256'(m_cnt[0]));
            chk("d0.ovf",   256'(b0.ovf),   256'(m_ovf[0]));
            chk("d0.valid", 256'(b0.valid), 256'(m_vld[0]));
            chk("d1.y",     256'(b1.y),     m_y[1]);
            chk("d1.cnt",   256'(b1.cnt),   256'(m_cnt[1]));
            chk("d1.ovf",   256'(b1.ovf),   256'(m_ovf[1]));
            chk("d1.valid", 256'(b1.valid), 256'(m_vld[1]));
            chk("d2.y",     256'(b2.y),     m_y[2]);
            chk("d2.cnt",   256'(b2.cnt),   256'(m_cnt[2]));
            chk("d2.ovf",   256'(b2.ovf),   256'(m_ovf[2]));
            chk("d2.valid", 256'(b2.valid), 256'(m_vld[2]));
            if (b0.valid) vcnt0++;
        end
    end

    typedef struct {
        logic [1:0]  m;
        logic [31:0] x;
    } smp_t;

    smp_t mix [7];

    initial begin
        mix[0] = '{2'd2, 32'd1};
        mix[1] = '{2'd2, 32'd2};
        mix[2] = '{2'd2, 32'd3};
        mix[3] = '{2'd2, 32'd4};
        mix[4] = '{2'd1, 32'd3};
        mix[5] = '{2'd1, 32'd4};
        mix[6] = '{2'd3, 32'd5};

        // Reset with a live sample presented throughout.
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'd7);
        step();
        step();
        chk("rst.y",     256'(b0.y),     256'd0);
        chk("rst.cnt",   256'(b0.cnt),   256'd0);
        chk("rst.ovf",   256'(b0.ovf),   256'd0);
        chk("rst.valid", 256'(b0.valid), 256'd0);
        idle(5);
        chk("rst.nothing_absorbed", 256'(b0.y), 256'd0);

        // Mode 0 sum of 1..10; also saturates d2's 3-bit counter.
        vcnt0 = 0;
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 1'b0, 1'b1, 2'd0, 32'(k));
            step();
        end
        idle(3);
        chk("sum10.y",      256'(b0.y),   256'd55);
        chk("sum10.cnt",    256'(b0.cnt), 256'd10);
        chk("sum10.cntsat", 256'(b2.cnt), 256'd7);
        idle(2);
        chk("sum10.valid_pulses", 256'(vcnt0), 256'd10);
        clear();

        // Mixed modes back to back, then with gaps.
        foreach (mix[k]) begin
            drive(1'b0, 1'b0, 1'b1, mix[k].m, mix[k].x);
            step();
        end
        idle(3);
        chk("mix.y",   256'(b0.y),   256'd130);
        chk("mix.cnt", 256'(b0.cnt), 256'd7);
        clear();
        foreach (mix[k]) begin
            drive(1'b0, 1'b0, 1'b1, mix[k].m, mix[k].x);
            step();
            idle(k % 3 + 1);
        end
        idle(3);
        chk("mixgap.y", 256'(b0.y), 256'd130);
        clear();

        // Saturation on the narrow instance.
        drive(1'b0, 1'b0, 1'b1, 2'd1, 32'd15);
        step();
        idle(3);
        chk("sat1.y",   256'(b1.y),   256'd225);
        chk("sat1.ovf", 256'(b1.ovf), 256'd0);
        drive(1'b0, 1'b0, 1'b1, 2'd1, 32'd15);
        step();
        idle(3);
        chk("sat2.y",   256'(b1.y),   256'd255);
        chk("sat2.ovf", 256'(b1.ovf), 256'd1);
        drive(1'b0, 1'b0, 1'b1, 2'd0, 32'd1);
        step();
        idle(3);
        chk("sat3.y",   256'(b1.y),   256'd255);
        chk("sat3.ovf", 256'(b1.ovf), 256'd1);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
        step();
        chk("satclr.y",   256'(b1.y),   256'd0);
        chk("satclr.ovf", 256'(b1.ovf), 256'd0);
        idle(3);

        // Clear mid-stream with a sample on the clearing edge.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, 2'd0, 32'd100);
            step();
        end
        drive(1'b0, 1'b1, 1'b1, 2'd0, 32'd5);
        step();
        chk("clrmid.y3",   256'(b0.y),   256'd0);
        chk("clrmid.cnt3", 256'(b0.cnt), 256'd0);
        idle(2);
        chk("clrmid.y5", 256'(b0.y), 256'd0);
        idle(1);
        chk("clrmid.y6",   256'(b0.y),   256'd5);
        chk("clrmid.cnt6", 256'(b0.cnt), 256'd1);
        clear();

        // Counter saturation: ten samples of 1 on CNT_W=3.
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, 1'b1, 2'd0, 32'd1);
            step();
        end
        idle(3);
        chk("cntsat.cnt", 256'(b2.cnt), 256'd7);
        chk("cntsat.y",   256'(b2.y),   256'd10);
        idle(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
